// File: rtl/afpm_stream_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : afpm_stream_ctrl_pkg
// Description : Shared float32 definitions for the approximate FP multiplier
//               stream controller. Provides the float32 type, field widths,
//               result-flag bit positions and a flag classification helper.
// Revision    : 1.0 - initial release
// ============================================================================
package afpm_stream_ctrl_pkg;

    localparam int FLOAT32_EXP_WIDTH = 8;
    localparam int FLOAT32_SIG_WIDTH = 23;

    typedef logic [31:0] float32_t;

    // Bit positions inside the 3-bit {nan, inf, zero} flag vector.
    localparam int FLAG_W        = 3;
    localparam int FLAG_NAN_IDX  = 2;
    localparam int FLAG_INF_IDX  = 1;
    localparam int FLAG_ZERO_IDX = 0;

    // Classifies a float32 value; the sign bit does not affect any flag.
    function automatic logic [FLAG_W-1:0] float32_flags(input float32_t v);
        logic              w_exp_ones;
        logic              w_exp_zero;
        logic              w_sig_zero;
        logic [FLAG_W-1:0] w_f;
        w_exp_ones = &v[FLOAT32_SIG_WIDTH +: FLOAT32_EXP_WIDTH];
        w_exp_zero = ~|v[FLOAT32_SIG_WIDTH +: FLOAT32_EXP_WIDTH];
        w_sig_zero = ~|v[FLOAT32_SIG_WIDTH-1:0];
        w_f                = '0;
        w_f[FLAG_NAN_IDX]  = w_exp_ones & ~w_sig_zero;
        w_f[FLAG_INF_IDX]  = w_exp_ones &  w_sig_zero;
        w_f[FLAG_ZERO_IDX] = w_exp_zero &  w_sig_zero;
        return w_f;
    endfunction

endpackage
`default_nettype wire

// File: rtl/afpm_op_fifo.sv
`default_nettype none
// ============================================================================
// Module      : afpm_op_fifo
// Description : Operand FIFO for the stream controller. DEPTH entries of
//               WIDTH bits, head visible combinationally on rdata.
// Ports       : clk, resetn (async active-low), flush (sync clear),
//               push/wdata (write tail), pop (drop head), rdata (head),
//               full, empty.
// Revision    : 1.0 - initial release
// ============================================================================
module afpm_op_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 68
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int           AW      = $clog2(DEPTH);
    localparam logic [AW:0]  PTR_ONE = {{AW{1'b0}}, 1'b1};

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;
    logic [WIDTH-1:0] r_mem [DEPTH];

    logic w_wr;
    logic w_rd;

    assign empty = (r_wptr == r_rptr);
    assign full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_wr  = push & ~full & ~flush;
    assign w_rd  = pop & ~empty & ~flush;
    assign rdata = r_mem[r_rptr[AW-1:0]];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else if (flush) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_wr) r_wptr <= r_wptr + PTR_ONE;
            if (w_rd) r_rptr <= r_rptr + PTR_ONE;
        end
    end

    // Storage needs no reset: an entry is only observed after being written.
    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wptr[AW-1:0]] <= wdata;
    end

endmodule
`default_nettype wire

// File: rtl/afpm_stream_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : afpm_stream_ctrl
// Description : Streaming wrapper around an external combinational
//               approximate float32 multiplier. Operands are queued in a
//               FIFO, the head is presented on mul_a/mul_b, and the product
//               is captured with its tag and {nan,inf,zero} flags into a
//               single output register with a valid/ready handshake.
// Ports       : clk, resetn (async active-low), flush (sync clear)
//               in_valid/in_ready/in_a/in_b/in_tag   - upstream stream
//               mul_a/mul_b -> multiplier, mul_p <- product
//               out_valid/out_ready/out_p/out_tag/out_flags - downstream
//               busy, op_count (completed output handshakes, wraps)
// Revision    : 1.0 - initial release
// ============================================================================
module afpm_stream_ctrl
    import afpm_stream_ctrl_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  float32_t          in_a,
    input  float32_t          in_b,
    input  logic [TAG_W-1:0]  in_tag,
    output float32_t          mul_a,
    output float32_t          mul_b,
    input  float32_t          mul_p,
    output logic              out_valid,
    input  logic              out_ready,
    output float32_t          out_p,
    output logic [TAG_W-1:0]  out_tag,
    output logic [FLAG_W-1:0] out_flags,
    output logic              busy,
    output logic [15:0]       op_count
);

    localparam int        ENTRY_W  = 64 + TAG_W;
    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

    logic [0:0]         r_state;
    float32_t           r_out_p;
    logic [TAG_W-1:0]   r_out_tag;
    logic [FLAG_W-1:0]  r_out_flags;
    logic [15:0]        r_op_count;

    logic               w_fifo_full;
    logic               w_fifo_empty;
    logic [ENTRY_W-1:0] w_head;
    logic               w_push;
    logic               w_out_hs;
    logic               w_issue;
    float32_t           w_head_a;
    float32_t           w_head_b;
    logic [TAG_W-1:0]   w_head_tag;

    // A pop in the same cycle does not free a slot for the push: in_ready
    // depends on the registered full flag only.
    assign in_ready = ~w_fifo_full & ~flush;
    assign w_push   = in_valid & in_ready;

    assign out_valid = (r_state == ST_FULL);
    assign w_out_hs  = out_valid & out_ready;

    // The output register can take a new result when empty or when its
    // current result leaves this cycle, giving one result per cycle.
    assign w_issue = ~w_fifo_empty & ((r_state == ST_EMPTY) | w_out_hs);

    afpm_op_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk    (clk),
        .resetn (resetn),
        .flush  (flush),
        .push   (w_push),
        .wdata  ({in_a, in_b, in_tag}),
        .pop    (w_issue),
        .rdata  (w_head),
        .full   (w_fifo_full),
        .empty  (w_fifo_empty)
    );

    assign w_head_a   = w_head[TAG_W+32 +: 32];
    assign w_head_b   = w_head[TAG_W    +: 32];
    assign w_head_tag = w_head[TAG_W-1:0];

    // Stale FIFO storage is never shown to the multiplier.
    assign mul_a = w_fifo_empty ? 32'h0 : w_head_a;
    assign mul_b = w_fifo_empty ? 32'h0 : w_head_b;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= ST_EMPTY;
        end else if (flush) begin
            r_state <= ST_EMPTY;
        end else if (w_issue) begin
            r_state <= ST_FULL;
        end else if (w_out_hs) begin
            r_state <= ST_EMPTY;
        end
    end

    // Data fields only change on issue, so they hold under backpressure.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_out_p     <= '0;
            r_out_tag   <= '0;
            r_out_flags <= '0;
        end else if (!flush && w_issue) begin
            r_out_p     <= mul_p;
            r_out_tag   <= w_head_tag;
            r_out_flags <= float32_flags(mul_p);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_op_count <= '0;
        end else if (!flush && w_out_hs) begin
            r_op_count <= r_op_count + 16'd1;
        end
    end

    assign out_p     = r_out_p;
    assign out_tag   = r_out_tag;
    assign out_flags = r_out_flags;
    assign op_count  = r_op_count;
    assign busy      = ~w_fifo_empty | (r_state == ST_FULL);

endmodule
`default_nettype wire
